// File: rtl/uart_rx_frontend_if.sv
// Bus-side port bundle of the UART receive front end.
// Handshake: the receiver (master) raises rx_valid with rx_data whenever its
// holding buffer is full and keeps rx_data stable until a transfer. A
// transfer happens on every rising clk edge where rx_valid & rx_ready are
// both 1. rx_ready may be held high permanently. rx_valid never waits on
// rx_ready. The three error outputs are single-cycle pulses with no handshake.
interface uart_rx_frontend_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_parity_err;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      output rx_frame_err,
      output rx_overrun,
      output rx_parity_err
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      input  rx_frame_err,
      input  rx_overrun,
      input  rx_parity_err
   );
endinterface

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver with a 1-entry holding buffer.
// Rx_Serial is synchronised by two flops, deframed by a mid-bit sampling
// FSM, and the finished byte is offered to the bus through a valid/ready
// buffer. Framing errors and overruns are reported as 1-cycle pulses.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit after
// data bit 7 (PARITY_ODD selects odd parity). Without it the receiver is
// pure 8N1 and rx_parity_err is tied 0.
// dbg_state codes: 0 IDLE, 1 START, 2 DATA, 3 STOP, 4 BREAK, 5 PARITY.
module uart_rx_frontend #(
   parameter int CLKS_PER_BIT = 868,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Rx_Serial,
   uart_rx_frontend_if.master bus,
   output logic [2:0]         dbg_state
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
   localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd5;
`endif

   logic          sync1;
   logic          rx_s;
   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic          byte_done;   // good frame finished last cycle, shift_reg holds it
   logic          par_ok;

`ifdef UART_RX_PARITY_EN
   logic par_bit;
   logic par_err_q;
   assign par_ok            = (par_bit == (^shift_reg ^ PARITY_ODD));
   assign bus.rx_parity_err = par_err_q;
`else
   logic unused_parity_cfg;
   assign par_ok            = 1'b1;
   assign unused_parity_cfg = PARITY_ODD;
   assign bus.rx_parity_err = 1'b0;
`endif

   assign dbg_state = state;

   // Two-flop synchroniser; resets to the idle (high) line level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= Rx_Serial;
         rx_s  <= sync1;
      end
   end

   // Deframing FSM: sample each bit in its middle, flag bad stop/parity bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= S_IDLE;
         cnt              <= '0;
         bit_idx          <= '0;
         shift_reg        <= '0;
         byte_done        <= 1'b0;
         bus.rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit          <= 1'b0;
         par_err_q        <= 1'b0;
`endif
      end else begin
         byte_done        <= 1'b0;
         bus.rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q        <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (!rx_s) state <= S_START;
            end
            S_START: begin
               if (cnt == HALF_M1) begin
                  // A start bit that is high again at its middle was a glitch.
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt == FULL_M1) begin
                  cnt       <= '0;
                  shift_reg <= {rx_s, shift_reg[7:1]};
                  bit_idx   <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt == FULL_M1) begin
                  cnt     <= '0;
                  par_bit <= rx_s;
                  state   <= S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (cnt == FULL_M1) begin
                  cnt <= '0;
`ifdef UART_RX_PARITY_EN
                  par_err_q <= !par_ok;
`endif
                  if (rx_s) begin
                     byte_done <= par_ok;
                     state     <= S_IDLE;
                  end else begin
                     bus.rx_frame_err <= 1'b1;
                     state            <= S_BREAK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_BREAK: begin
               // Hold off until the line returns high so a held-low line flags once.
               cnt <= '0;
               if (rx_s) state <= S_IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Holding buffer: load a finished byte if free or draining, else report overrun.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.rx_data    <= '0;
         bus.rx_valid   <= 1'b0;
         bus.rx_overrun <= 1'b0;
      end else begin
         bus.rx_overrun <= 1'b0;
         if (byte_done) begin
            if (!bus.rx_valid || bus.rx_ready) begin
               bus.rx_data  <= shift_reg;
               bus.rx_valid <= 1'b1;
            end else begin
               bus.rx_overrun <= 1'b1;
            end
         end else if (bus.rx_valid && bus.rx_ready) begin
            bus.rx_valid <= 1'b0;
         end
      end
   end

endmodule
